// File: rtl/calc_seq_ctrl_pkg.sv
// Shared types and encodings for the calculator sequencing controller.
package calc_pkg;

  // Controller states; the encoding is exported on state_dbg.
  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_OP = 3'd1,
    WAIT_B  = 3'd2,
    WAIT_EQ = 3'd3,
    EXEC    = 3'd4,
    BUSY    = 3'd5,
    DONE    = 3'd6
  } state_e;

  // Token kinds from the keypad decoder.
  localparam logic [1:0] KIND_OPND = 2'b00;
  localparam logic [1:0] KIND_OPR  = 2'b01;
  localparam logic [1:0] KIND_EQ   = 2'b10;
  localparam logic [1:0] KIND_CLR  = 2'b11;

  // Error codes reported on err_code.
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TOKEN   = 2'b01;
  localparam logic [1:0] ERR_DIV0    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // ALU opcodes.
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;

  // Single-cycle datapath strobes, registered together so at most one fires.
  typedef struct packed {
    logic a_we;
    logic b_we;
    logic op_we;
    logic reg_clr;
    logic alu_start;
    logic res_we;
  } strobe_t;

  // States in which the controller takes tokens from the decoder.
  function automatic logic is_accepting(input state_e s);
    return (s == WAIT_A) || (s == WAIT_OP) || (s == WAIT_B) || (s == WAIT_EQ);
  endfunction

endpackage

// File: rtl/calc_seq_ctrl_if.sv
// Token stream from the keypad decoder into the sequencing controller.
interface calc_seq_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_kind;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_kind, output in_data, input in_ready);
  modport slave  (input in_valid, input in_kind, input in_data, output in_ready);
endinterface

// File: rtl/calc_seq_ctrl_watchdog.sv
// ALU watchdog: counts BUSY cycles from alu_start and flags expiry on the
// cycle the count reaches TO_CYCLES-1, so the timeout error lands exactly
// TO_CYCLES cycles after alu_start.
module calc_alu_watchdog #(
  parameter int TO_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clr,
  input  logic run,
  output logic expire
);
  localparam int              CW   = $clog2(TO_CYCLES);
  localparam logic [CW-1:0]   LAST = CW'(TO_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign expire = run && (cnt == LAST);

  // Restart on start/clear, otherwise count up while the ALU is running.
  always_ff @(posedge clk) begin
    if (rst || start || clr) cnt <= '0;
    else if (run && !expire)  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencing controller: turns decoder tokens into register
// write strobes, launches the ALU, captures and presents the result.
// Optional macro CALC_CHAIN_EN: after the result is consumed, load it back
// into A (a_src_sel) and continue at WAIT_OP so operations can chain.
module calc_seq_ctrl #(
  parameter int              DATA_W    = 8,
  parameter int              OP_W      = 3,
  parameter int              TO_CYCLES = 32,
  parameter logic [OP_W-1:0] OP_DIV    = 3'd3
) (
  input  logic              clk,
  input  logic              rst,
  calc_seq_ctrl_if.slave    tok,
  output logic [DATA_W-1:0] opnd_d,
  output logic [OP_W-1:0]   op_d,
  output logic              a_we,
  output logic              b_we,
  output logic              op_we,
  output logic              reg_clr,
  output logic              alu_start,
  input  logic              alu_done,
  output logic              res_we,
  output logic              res_valid,
  input  logic              res_ack,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [2:0]        state_dbg
`ifdef CALC_CHAIN_EN
  ,
  output logic              a_src_sel
`endif
);
  import calc_pkg::*;

  state_e            state_q, state_n;
  strobe_t           stb_q, stb_n;
  logic              err_q, err_n;
  logic [1:0]        code_q, code_n;
  logic [DATA_W-1:0] opnd_q, opnd_n;
  logic [OP_W-1:0]   op_q, op_n;
  logic              bz_q, bz_n;
  logic              rv_q, rv_n;
  logic              accept;
  logic              wd_start, wd_clr, wd_expire;
`ifdef CALC_CHAIN_EN
  logic              src_q, src_n;
`endif

  assign tok.in_ready = !rst && is_accepting(state_q);
  assign accept       = tok.in_valid && tok.in_ready;

  calc_alu_watchdog #(.TO_CYCLES(TO_CYCLES)) u_wd (
    .clk    (clk),
    .rst    (rst),
    .start  (wd_start),
    .clr    (wd_clr),
    .run    (state_q == BUSY),
    .expire (wd_expire)
  );

  // Next state and next registered outputs; strobes default to idle.
  always_comb begin
    state_n  = state_q;
    stb_n    = '0;
    err_n    = 1'b0;
    code_n   = code_q;
    opnd_n   = opnd_q;
    op_n     = op_q;
    bz_n     = bz_q;
    rv_n     = rv_q;
    wd_start = 1'b0;
    wd_clr   = 1'b0;
`ifdef CALC_CHAIN_EN
    src_n    = 1'b0;
`endif
    if (accept && tok.in_kind == KIND_CLR) begin
      stb_n.reg_clr = 1'b1;
      state_n       = WAIT_A;
    end else begin
      unique case (state_q)
        WAIT_A: if (accept) begin
          if (tok.in_kind == KIND_OPND) begin
            stb_n.a_we = 1'b1;
            opnd_n     = tok.in_data;
            state_n    = WAIT_OP;
          end else begin
            err_n  = 1'b1;
            code_n = ERR_TOKEN;
          end
        end
        WAIT_OP: if (accept) begin
          if (tok.in_kind == KIND_OPR) begin
            stb_n.op_we = 1'b1;
            op_n        = tok.in_data[OP_W-1:0];
            state_n     = WAIT_B;
          end else if (tok.in_kind == KIND_OPND) begin
            stb_n.a_we = 1'b1;
            opnd_n     = tok.in_data;
          end else begin
            err_n  = 1'b1;
            code_n = ERR_TOKEN;
          end
        end
        WAIT_B: if (accept) begin
          if (tok.in_kind == KIND_OPND) begin
            stb_n.b_we = 1'b1;
            opnd_n     = tok.in_data;
            bz_n       = (tok.in_data == '0);
            state_n    = WAIT_EQ;
          end else if (tok.in_kind == KIND_OPR) begin
            stb_n.op_we = 1'b1;
            op_n        = tok.in_data[OP_W-1:0];
          end else begin
            err_n  = 1'b1;
            code_n = ERR_TOKEN;
          end
        end
        WAIT_EQ: if (accept) begin
          if (tok.in_kind == KIND_EQ) begin
            state_n = EXEC;
          end else if (tok.in_kind == KIND_OPND) begin
            stb_n.b_we = 1'b1;
            opnd_n     = tok.in_data;
            bz_n       = (tok.in_data == '0);
          end else begin
            err_n  = 1'b1;
            code_n = ERR_TOKEN;
          end
        end
        EXEC: begin
          // Divide by zero is caught here so the ALU never sees it.
          if (op_q == OP_DIV && bz_q) begin
            err_n         = 1'b1;
            code_n        = ERR_DIV0;
            stb_n.reg_clr = 1'b1;
            state_n       = WAIT_A;
          end else begin
            stb_n.alu_start = 1'b1;
            wd_start        = 1'b1;
            state_n         = BUSY;
          end
        end
        BUSY: begin
          // done wins over a same-cycle timeout
          if (alu_done) begin
            stb_n.res_we = 1'b1;
            wd_clr       = 1'b1;
            state_n      = DONE;
          end else if (wd_expire) begin
            err_n         = 1'b1;
            code_n        = ERR_TIMEOUT;
            stb_n.reg_clr = 1'b1;
            wd_clr        = 1'b1;
            state_n       = WAIT_A;
          end
        end
        DONE: begin
          if (stb_q.res_we) rv_n = 1'b1;
          if (rv_q && res_ack) begin
            rv_n = 1'b0;
`ifdef CALC_CHAIN_EN
            stb_n.a_we = 1'b1;
            src_n      = 1'b1;
            state_n    = WAIT_OP;
`else
            state_n    = WAIT_A;
`endif
          end
        end
        default: state_n = WAIT_A;
      endcase
    end
  end

  // State and registered outputs; reset overrides tokens and alu_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_A;
      stb_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      opnd_q  <= '0;
      op_q    <= '0;
      bz_q    <= 1'b0;
      rv_q    <= 1'b0;
`ifdef CALC_CHAIN_EN
      src_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      stb_q   <= stb_n;
      err_q   <= err_n;
      code_q  <= code_n;
      opnd_q  <= opnd_n;
      op_q    <= op_n;
      bz_q    <= bz_n;
      rv_q    <= rv_n;
`ifdef CALC_CHAIN_EN
      src_q   <= src_n;
`endif
    end
  end

  assign opnd_d    = opnd_q;
  assign op_d      = op_q;
  assign a_we      = stb_q.a_we;
  assign b_we      = stb_q.b_we;
  assign op_we     = stb_q.op_we;
  assign reg_clr   = stb_q.reg_clr;
  assign alu_start = stb_q.alu_start;
  assign res_we    = stb_q.res_we;
  assign res_valid = rv_q;
  assign err       = err_q;
  assign err_code  = code_q;
  assign state_dbg = state_q;
`ifdef CALC_CHAIN_EN
  assign a_src_sel = src_q;
`endif
endmodule
